// File: rtl/puf_pkg.sv
// Shared types and helpers for the RO-PUF challenge sequencer.
package puf_pkg;

  localparam int unsigned N_RO  = 16;
  localparam int unsigned SEL_W = $clog2(N_RO);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EVAL,
    SAMPLE,
    DONE
  } state_e;

  // RO index for pair k: (base + k + offset) mod N_RO via SEL_W-bit wrap-around.
  function automatic logic [SEL_W-1:0] sel_wrap(input logic [SEL_W-1:0] base,
                                                input int unsigned      k,
                                                input logic [SEL_W-1:0] offset);
    return SEL_W'(32'(base) + k + 32'(offset));
  endfunction

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter; tc_o is high while the loaded window has expired.
module puf_window_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= (cnt_d == '0);
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Issues RO challenge pairs, times settle/eval windows and packs responses into a word.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int unsigned RESP_BITS     = 8,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned EVAL_CYCLES   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_W-1:0]     base_sel,
  input  logic [SEL_W-1:0]     offset,
  input  logic                 response,
  output logic [SEL_W-1:0]     cha0,
  output logic [SEL_W-1:0]     cha1,
  output logic                 cnt_run,
  output logic                 busy,
  output logic                 cfg_err,
  output logic [RESP_BITS-1:0] resp_word,
  output logic                 resp_valid,
  input  logic                 resp_ready
);

  localparam int unsigned T_MAX = (SETTLE_CYCLES > EVAL_CYCLES) ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int unsigned T_W   = $clog2(T_MAX + 1);
  localparam int unsigned K_W   = $clog2(RESP_BITS + 1);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     base_q, base_d, offset_q, offset_d;
  logic [SEL_W-1:0]     cha0_q, cha0_d, cha1_q, cha1_d;
  logic [K_W-1:0]       k_q, k_d, k_nxt;
  logic                 cnt_run_q, cnt_run_d, busy_q, busy_d;
  logic                 cfg_err_q, cfg_err_d, resp_valid_q, resp_valid_d;
  logic [RESP_BITS-1:0] resp_word_q, resp_word_d;
  logic                 tmr_load, tmr_tc;
  logic [T_W-1:0]       tmr_val;

  puf_window_timer #(.W(T_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tc_o      (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      offset_q     <= '0;
      cha0_q       <= '0;
      cha1_q       <= '0;
      k_q          <= '0;
      cnt_run_q    <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      resp_word_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      cha0_q       <= cha0_d;
      cha1_q       <= cha1_d;
      k_q          <= k_d;
      cnt_run_q    <= cnt_run_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
      resp_word_q  <= resp_word_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  // Registered outputs are computed from the next state so they line up with state entry.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    offset_d     = offset_q;
    cha0_d       = cha0_q;
    cha1_d       = cha1_q;
    k_d          = k_q;
    k_nxt        = k_q + K_W'(1);
    cnt_run_d    = cnt_run_q;
    busy_d       = busy_q;
    cfg_err_d    = 1'b0;
    resp_word_d  = resp_word_q;
    resp_valid_d = resp_valid_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (offset != '0) begin
            base_d      = base_sel;
            offset_d    = offset;
            k_d         = '0;
            busy_d      = 1'b1;
            resp_word_d = '0;
            cha0_d      = sel_wrap(base_sel, 0, '0);
            cha1_d      = sel_wrap(base_sel, 0, offset);
            cnt_run_d   = 1'b0;
            tmr_load    = 1'b1;
            tmr_val     = T_W'(SETTLE_CYCLES - 1);
            state_d     = SETUP;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (tmr_tc) begin
          cnt_run_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = T_W'(EVAL_CYCLES - 1);
          state_d   = EVAL;
        end
      end
      EVAL: begin
        if (tmr_tc) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        // Bit k is still zero here, so OR-ing in the response never disturbs earlier pairs.
        resp_word_d = resp_word_q | (RESP_BITS'(response) << k_q);
        cnt_run_d   = 1'b0;
        if (k_q == K_W'(RESP_BITS - 1)) begin
          resp_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = DONE;
        end else begin
          k_d      = k_nxt;
          cha0_d   = sel_wrap(base_q, 32'(k_nxt), '0);
          cha1_d   = sel_wrap(base_q, 32'(k_nxt), offset_q);
          tmr_load = 1'b1;
          tmr_val  = T_W'(SETTLE_CYCLES - 1);
          state_d  = SETUP;
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cha0       = cha0_q;
  assign cha1       = cha1_q;
  assign cnt_run    = cnt_run_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;
  assign resp_word  = resp_word_q;
  assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer with a behavioural RO counter/comparator model.
module tb_puf_challenge_sequencer;
  import puf_pkg::*;

  localparam int unsigned RB   = 8;
  localparam int unsigned ST   = 2;
  localparam int unsigned EV   = 64;
  localparam int unsigned PAIR = ST + EV + 1;

  logic          clk = 1'b0;
  logic          reset, start, response, resp_ready;
  logic [SEL_W-1:0] base_sel, offset, cha0, cha1;
  logic          cnt_run, busy, cfg_err, resp_valid;
  logic [RB-1:0] resp_word;

  int unsigned period [N_RO] = '{default: 10};
  int unsigned run_n = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  puf_challenge_sequencer #(.RESP_BITS(RB), .SETTLE_CYCLES(ST), .EVAL_CYCLES(EV)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_sel  (base_sel),
    .offset    (offset),
    .response  (response),
    .cha0      (cha0),
    .cha1      (cha1),
    .cnt_run   (cnt_run),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .resp_word (resp_word),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready)
  );

  // Counter block: counts enabled cycles; each RO contributes one edge per period cycles.
  always @(posedge clk) run_n <= cnt_run ? run_n + 1 : 0;
  always_comb response = (run_n / period[cha0]) > (run_n / period[cha1]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB-1:0] exp_word(input int unsigned b, input int unsigned o);
    logic [RB-1:0] w = '0;
    for (int k = 0; k < RB; k++) begin
      int unsigned c0 = (b + k) % N_RO;
      int unsigned c1 = (b + k + o) % N_RO;
      if ((EV / period[c0]) > (EV / period[c1])) w = w | (RB'(1) << k);
    end
    return w;
  endfunction

  task automatic randomize_periods();
    for (int i = 0; i < N_RO; i++) period[i] = $urandom_range(25, 5);
  endtask

  task automatic run_check(input int unsigned b, input int unsigned o, input int unsigned stall);
    logic [RB-1:0] ew;
    int errs;
    ew = exp_word(b, o);
    base_sel = SEL_W'(b);
    offset   = SEL_W'(o);
    start    = 1'b1;
    tick();
    check("accept_busy", 32'(busy), 1);
    check("accept_word_clear", 32'(resp_word), 0);
    for (int k = 0; k < RB; k++) begin
      errs = 0;
      for (int c = 0; c < PAIR; c++) begin
        start    = 1'($urandom);
        base_sel = SEL_W'($urandom);
        offset   = SEL_W'($urandom);
        if (cnt_run !== ((c >= ST) ? 1'b1 : 1'b0)) errs++;
        if (cha0 !== SEL_W'((b + k) % N_RO)) errs++;
        if (cha1 !== SEL_W'((b + k + o) % N_RO)) errs++;
        if (busy !== 1'b1 || resp_valid !== 1'b0 || cfg_err !== 1'b0) errs++;
        tick();
      end
      check($sformatf("pair%0d_schedule", k), 32'(errs), 0);
    end
    start = 1'b0;
    check("done_valid", 32'(resp_valid), 1);
    check("done_busy", 32'(busy), 0);
    check("done_cnt_run", 32'(cnt_run), 0);
    check("done_word", 32'(resp_word), 32'(ew));
    errs = 0;
    resp_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      start  = 1'($urandom);
      offset = SEL_W'($urandom);
      tick();
      if (resp_valid !== 1'b1 || resp_word !== ew || busy !== 1'b0 || cfg_err !== 1'b0) errs++;
    end
    check("stall_stable", 32'(errs), 0);
    start      = 1'b1;
    offset     = SEL_W'(1);
    resp_ready = 1'b1;
    tick();
    start      = 1'b0;
    resp_ready = 1'b0;
    check("accept_valid_drop", 32'(resp_valid), 0);
    check("accept_word_held", 32'(resp_word), 32'(ew));
    tick();
    check("accept_start_ignored", 32'(busy), 0);
  endtask

  initial begin
    int unsigned b, o;
    reset = 1'b1; start = 1'b0; base_sel = '0; offset = '0; resp_ready = 1'b0;
    tick(); tick();
    check("rst_outputs", {cha0, cha1, cnt_run, busy, cfg_err, resp_valid}, 0);
    check("rst_word", 32'(resp_word), 0);
    reset = 1'b0;
    tick();

    // Illegal offset from reset state.
    base_sel = SEL_W'(5); offset = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 1);
    check("cfg_err_busy", 32'(busy), 0);
    check("cfg_err_outs", {cha0, cha1, cnt_run}, 0);
    tick();
    check("cfg_err_one_cycle", 32'(cfg_err), 0);
    check("cfg_err_still_idle", 32'(busy), 0);

    // Ready while idle has no effect.
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("idle_ready_noop", {busy, resp_valid}, 0);

    // Basic run: RO12 period 15, RO8 period 12.
    randomize_periods();
    period[12] = 15;
    period[8]  = 12;
    run_check(12, 12, 20);

    // Illegal offset after a run leaves the last challenge on the bus.
    base_sel = SEL_W'(2); offset = '0; start = 1'b1;
    tick();
    start = 1'b0;
    check("cfg_err2_pulse", 32'(cfg_err), 1);
    check("cfg_err2_cha", {cha0, cha1}, {SEL_W'(3), SEL_W'(15)});
    check("cfg_err2_quiet", {busy, cnt_run}, 0);
    tick();

    // Randomized runs.
    for (int r = 0; r < 2; r++) begin
      randomize_periods();
      b = $urandom_range(N_RO - 1, 0);
      o = $urandom_range(N_RO - 1, 1);
      run_check(b, o, $urandom_range(6, 1));
    end

    // Reset during EVAL of pair 3.
    randomize_periods();
    base_sel = SEL_W'(9); offset = SEL_W'(4); start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3 * PAIR + ST + 10; i++) tick();
    check("midrun_in_eval", {cnt_run, cha0}, {1'b1, SEL_W'(12)});
    reset = 1'b1;
    tick();
    check("midrun_rst_outputs", {cha0, cha1, cnt_run, busy, cfg_err, resp_valid}, 0);
    check("midrun_rst_word", 32'(resp_word), 0);
    reset = 1'b0;
    tick();
    b = $urandom_range(N_RO - 1, 0);
    o = $urandom_range(N_RO - 1, 1);
    run_check(b, o, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
